alarm_timer_ctrl: RTL and testbench

Alarm-system sequencer that owns the shared 10-bit loadable up-counter used for every alarm delay (exit, entry, siren duration).
- Runs the arm/disarm state machine.
- Generates the timebase tick.
- Drives the counter's load_en/load_value/En controls, and detects expiry from the counter's Qout.
- Sits between the keypad/sensor front end and the siren/LED outputs.

---
 rtl/alarm_pkg.sv | 24 ++
 rtl/alarm_tick_gen.sv | 29 ++
 rtl/alarm_timer_ctrl.sv | 108 ++++++++++
 tb/tb_alarm_timer_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencer: state encoding, counter geometry
// and the preload helper for the shared 10-bit up-counter.
package alarm_pkg;

    localparam int unsigned CNT_WIDTH = 10;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } alarm_state_e;

    // The counter counts up and expires at CNT_MAX, so preloading 1024-D gives
    // D ticks; a delay of 0 wraps to a preload of 0, i.e. 1024 ticks.
    function automatic logic [CNT_WIDTH-1:0] preload(input logic [CNT_WIDTH-1:0] delay);
        logic [CNT_WIDTH:0] full;
        full = {1'b1, {CNT_WIDTH{1'b0}}} - {1'b0, delay};
        return full[CNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// Timebase prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick on wrap.
// A clear restarts the count so the first tick after a counter load is a full period.
module alarm_tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clock50,
    input  logic Mr_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count;

    assign tick = (count == LAST) && !clear;

    always_ff @(posedge clock50 or negedge Mr_n) begin
        if (!Mr_n) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + PW'(1);
        end
    end

endmodule

// File: rtl/alarm_timer_ctrl.sv
// Alarm arm/disarm sequencer driving the shared loadable up-counter used for
// the exit, entry and siren delays; expiry is detected from the counter's Qout.
module alarm_timer_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned EXIT_DELAY  = 30,
    parameter int unsigned ENTRY_DELAY = 20,
    parameter int unsigned SIREN_TIME  = 180
) (
    input  logic                 clock50,
    input  logic                 Mr_n,
    input  logic                 arm_req,
    input  logic                 disarm_req,
    input  logic                 sensor_trip,
    input  logic                 panic,
    input  logic [CNT_WIDTH-1:0] cnt_qout,
    output logic                 cnt_load_en,
    output logic [CNT_WIDTH-1:0] cnt_load_value,
    output logic                 cnt_en,
    output logic [2:0]           state_o,
    output logic                 armed,
    output logic                 siren,
    output logic                 beeper
);

    localparam logic [CNT_WIDTH-1:0] EXIT_LOAD  = preload(CNT_WIDTH'(EXIT_DELAY));
    localparam logic [CNT_WIDTH-1:0] ENTRY_LOAD = preload(CNT_WIDTH'(ENTRY_DELAY));
    localparam logic [CNT_WIDTH-1:0] SIREN_LOAD = preload(CNT_WIDTH'(SIREN_TIME));

    alarm_state_e         state;
    alarm_state_e         state_nx;
    logic                 tick;
    logic                 timed_state;
    logic                 expiry;
    logic                 load_nx;
    logic [CNT_WIDTH-1:0] load_value_nx;

    alarm_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clock50(clock50),
        .Mr_n   (Mr_n),
        .clear  (cnt_load_en),
        .tick   (tick)
    );

    assign timed_state = (state == ST_EXIT) || (state == ST_ENTRY) || (state == ST_ALARM);
    assign cnt_en      = tick && timed_state && !cnt_load_en;
    // cnt_en is low during the load cycle, so a stale Qout can never expire.
    assign expiry      = cnt_en && (cnt_qout == CNT_MAX);
    assign state_o     = state;

    always_comb begin
        state_nx = state;
        if (disarm_req) begin
            state_nx = ST_DISARMED;
        end else if (panic && (state != ST_ALARM)) begin
            state_nx = ST_ALARM;
        end else if (expiry) begin
            case (state)
                ST_EXIT:  state_nx = ST_ARMED;
                ST_ENTRY: state_nx = ST_ALARM;
                ST_ALARM: state_nx = ST_ARMED;
                default:  state_nx = state;
            endcase
        end else begin
            case (state)
                ST_DISARMED: if (arm_req)     state_nx = ST_EXIT;
                ST_ARMED:    if (sensor_trip) state_nx = ST_ENTRY;
                default:     state_nx = state;
            endcase
        end
    end

    always_comb begin
        load_value_nx = '0;
        case (state_nx)
            ST_EXIT:  load_value_nx = EXIT_LOAD;
            ST_ENTRY: load_value_nx = ENTRY_LOAD;
            ST_ALARM: load_value_nx = SIREN_LOAD;
            default:  load_value_nx = '0;
        endcase
        load_nx = (state_nx != state) &&
                  ((state_nx == ST_EXIT) || (state_nx == ST_ENTRY) || (state_nx == ST_ALARM));
    end

    always_ff @(posedge clock50 or negedge Mr_n) begin
        if (!Mr_n) begin
            state          <= ST_DISARMED;
            cnt_load_en    <= 1'b0;
            cnt_load_value <= '0;
            armed          <= 1'b0;
            siren          <= 1'b0;
            beeper         <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt_load_en <= load_nx;
            if (load_nx) begin
                cnt_load_value <= load_value_nx;
            end
            armed  <= (state_nx == ST_ARMED) || (state_nx == ST_ENTRY) || (state_nx == ST_ALARM);
            siren  <= (state_nx == ST_ALARM);
            beeper <= (state_nx == ST_EXIT) || (state_nx == ST_ENTRY);
        end
    end

endmodule

// File: tb/tb_alarm_timer_ctrl.sv
// Bench for alarm_timer_ctrl with a behavioural 10-bit loadable counter alongside.
module tb_alarm_timer_ctrl;

    localparam int unsigned TD      = 4;
    localparam int unsigned EXIT_D  = 3;
    localparam int unsigned ENTRY_D = 2;
    localparam int unsigned SIREN_D = 5;

    logic       clock50 = 1'b0;
    logic       Mr_n = 1'b0;
    logic       arm_req = 1'b0;
    logic       disarm_req = 1'b0;
    logic       sensor_trip = 1'b0;
    logic       panic = 1'b0;
    logic [9:0] cnt_qout;
    logic       cnt_load_en;
    logic [9:0] cnt_load_value;
    logic       cnt_en;
    logic [2:0] state_o;
    logic       armed;
    logic       siren;
    logic       beeper;

    logic [9:0] cnt_q = 10'd1023;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always #5 clock50 = ~clock50;

    alarm_timer_ctrl #(
        .TICK_DIV   (TD),
        .EXIT_DELAY (EXIT_D),
        .ENTRY_DELAY(ENTRY_D),
        .SIREN_TIME (SIREN_D)
    ) dut (
        .clock50       (clock50),
        .Mr_n          (Mr_n),
        .arm_req       (arm_req),
        .disarm_req    (disarm_req),
        .sensor_trip   (sensor_trip),
        .panic         (panic),
        .cnt_qout      (cnt_qout),
        .cnt_load_en   (cnt_load_en),
        .cnt_load_value(cnt_load_value),
        .cnt_en        (cnt_en),
        .state_o       (state_o),
        .armed         (armed),
        .siren         (siren),
        .beeper        (beeper)
    );

    // Existing shared counter; its master reset is tied inactive.
    always @(posedge clock50) begin
        if (cnt_load_en)  cnt_q <= cnt_load_value;
        else if (cnt_en)  cnt_q <= cnt_q + 10'd1;
    end
    assign cnt_qout = cnt_q;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // {armed, siren, beeper} for a given state number
    function automatic int flags_of(input int s);
        case (s)
            1: return 3'b001;
            2: return 3'b100;
            3: return 3'b101;
            4: return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit timed(input int s);
        return (s == 1) || (s == 3) || (s == 4);
    endfunction

    function automatic int delay_of(input int s);
        case (s)
            1: return EXIT_D;
            3: return ENTRY_D;
            default: return SIREN_D;
        endcase
    endfunction

    task automatic check_state(input string name, input int s);
        check({name, "_state"}, state_o, s);
        check({name, "_flags"}, {armed, siren, beeper}, flags_of(s));
    endtask

    task automatic wait_state(input string name, input int target, input int budget,
                              output int pulses, output int cycles);
        pulses = 0;
        cycles = 0;
        while ((state_o != 3'(target)) && (cycles < budget)) begin
            if (cnt_en) pulses++;
            @(negedge clock50);
            cycles++;
        end
        check({name, "_reached"}, state_o, target);
    endtask

    typedef struct {
        logic arm;
        logic disarm;
        logic sensor;
        logic panic;
        int   exp_state;
        logic exp_load;
        int   exp_lval;
    } vec_t;

    vec_t vecs[11];

    // reference model state
    int m_state, m_lval, load_cyc, ticks_left, c;
    bit m_load;

    initial begin
        int p, cy, cnt, loads, bad;
        bit a, d, s, pn, ten, exp_ev;
        int nxt, dl;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1021};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1021};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1021};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1019};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1019};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1019};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1019};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1019};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1019};

        // reset, then idle
        repeat (3) @(negedge clock50);
        check_state("reset", 0);
        check("reset_load_en", cnt_load_en, 0);
        check("reset_load_value", cnt_load_value, 0);
        check("reset_cnt_en", cnt_en, 0);
        Mr_n = 1'b1;
        cnt = 0;
        bad = 0;
        repeat (50) begin
            @(negedge clock50);
            if (cnt_en) cnt++;
            if (state_o != 3'd0) bad++;
        end
        check("idle_cnt_en_pulses", cnt, 0);
        check("idle_state_leaves", bad, 0);

        // single-step transition table
        for (int i = 0; i < 11; i++) begin
            arm_req     = vecs[i].arm;
            disarm_req  = vecs[i].disarm;
            sensor_trip = vecs[i].sensor;
            panic       = vecs[i].panic;
            @(negedge clock50);
            check($sformatf("vec%0d_state", i), state_o, vecs[i].exp_state);
            check($sformatf("vec%0d_flags", i), {armed, siren, beeper}, flags_of(vecs[i].exp_state));
            check($sformatf("vec%0d_load_en", i), cnt_load_en, vecs[i].exp_load);
            check($sformatf("vec%0d_load_value", i), cnt_load_value, vecs[i].exp_lval);
            check($sformatf("vec%0d_cnt_en", i), cnt_en, 0);
        end
        arm_req = 0; disarm_req = 0; sensor_trip = 0; panic = 0;

        // arm sequence: exit delay of 3 ticks
        arm_req = 1'b1;
        @(negedge clock50);
        arm_req = 1'b0;
        check_state("arm", 1);
        check("arm_load_en", cnt_load_en, 1);
        check("arm_load_value", cnt_load_value, 1021);
        wait_state("exit", 2, 200, p, cy);
        check("exit_pulses", p, EXIT_D);
        check("exit_cycles", cy, EXIT_D * TD + 1);
        check_state("armed", 2);
        check("armed_load_en", cnt_load_en, 0);

        // entry -> alarm -> auto re-arm, sensor held throughout
        sensor_trip = 1'b1;
        @(negedge clock50);
        check_state("entry", 3);
        check("entry_load_en", cnt_load_en, 1);
        check("entry_load_value", cnt_load_value, 1022);
        wait_state("entry_exp", 4, 200, p, cy);
        check("entry_pulses", p, ENTRY_D);
        check("entry_cycles", cy, ENTRY_D * TD + 1);
        check_state("alarm", 4);
        check("alarm_load_en", cnt_load_en, 1);
        check("alarm_load_value", cnt_load_value, 1019);
        wait_state("siren_exp", 2, 400, p, cy);
        sensor_trip = 1'b0;
        check("siren_pulses", p, SIREN_D);
        check("siren_cycles", cy, SIREN_D * TD + 1);
        check_state("rearm", 2);
        @(negedge clock50);
        check_state("rearm_hold", 2);

        // disarm wins over panic in ENTRY
        sensor_trip = 1'b1;
        @(negedge clock50);
        sensor_trip = 1'b0;
        @(negedge clock50);
        disarm_req = 1'b1;
        panic = 1'b1;
        @(negedge clock50);
        disarm_req = 1'b0;
        panic = 1'b0;
        check_state("disarm_prio", 0);
        check("disarm_prio_load_en", cnt_load_en, 0);
        check("disarm_prio_cnt_en", cnt_en, 0);
        cnt = 0;
        repeat (12) begin
            @(negedge clock50);
            if (cnt_en || cnt_load_en) cnt++;
        end
        check("disarmed_quiet", cnt, 0);

        // panic from DISARMED, held in ALARM
        panic = 1'b1;
        @(negedge clock50);
        check_state("panic", 4);
        check("panic_load_en", cnt_load_en, 1);
        check("panic_load_value", cnt_load_value, 1019);
        loads = 0;
        repeat (3) begin
            @(negedge clock50);
            if (cnt_load_en) loads++;
        end
        panic = 1'b0;
        check("panic_held_reloads", loads, 0);
        wait_state("panic_siren", 2, 400, p, cy);
        check("panic_siren_pulses", p, SIREN_D);
        check_state("panic_rearm", 2);

        // async reset mid-EXIT, then a full exit delay afterwards
        disarm_req = 1'b1;
        @(negedge clock50);
        disarm_req = 1'b0;
        arm_req = 1'b1;
        @(negedge clock50);
        arm_req = 1'b0;
        check_state("rst_arm", 1);
        cy = 0;
        while (!cnt_en && cy < 50) begin
            @(negedge clock50);
            cy++;
        end
        check("rst_first_tick", cnt_en, 1);
        @(negedge clock50);
        #2 Mr_n = 1'b0;
        #1;
        check_state("async_rst", 0);
        check("async_rst_load_en", cnt_load_en, 0);
        @(negedge clock50);
        Mr_n = 1'b1;
        arm_req = 1'b1;
        @(negedge clock50);
        arm_req = 1'b0;
        check_state("rearm_after_rst", 1);
        check("rearm_after_rst_load", cnt_load_value, 1021);
        wait_state("exit_after_rst", 2, 200, p, cy);
        check("exit_after_rst_pulses", p, EXIT_D);
        check("exit_after_rst_cycles", cy, EXIT_D * TD + 1);

        // randomized run against a tick-counting reference model
        Mr_n = 1'b0;
        @(negedge clock50);
        Mr_n = 1'b1;
        m_state = 0; m_load = 0; m_lval = 0; load_cyc = 0; ticks_left = 0; c = 0;
        for (int k = 0; k < 3000; k++) begin
            ten = timed(m_state) && !m_load && (c > load_cyc) && (((c - load_cyc) % TD) == 0);
            check("rnd_state", state_o, m_state);
            check("rnd_flags", {armed, siren, beeper}, flags_of(m_state));
            check("rnd_load_en", cnt_load_en, m_load);
            check("rnd_load_value", cnt_load_value, m_lval);
            check("rnd_cnt_en", cnt_en, ten);

            a  = ($urandom_range(0, 3) == 0);
            d  = ($urandom_range(0, 63) == 0);
            s  = ($urandom_range(0, 5) == 0);
            pn = ($urandom_range(0, 79) == 0);
            arm_req = a; disarm_req = d; sensor_trip = s; panic = pn;

            exp_ev = ten && (ticks_left == 1);
            if (ten && !exp_ev) ticks_left--;
            nxt = m_state;
            if (d)                         nxt = 0;
            else if (pn && m_state != 4)   nxt = 4;
            else if (exp_ev)               nxt = (m_state == 3) ? 4 : 2;
            else if (m_state == 2 && s)    nxt = 3;
            else if (m_state == 0 && a)    nxt = 1;
            if (nxt != m_state && timed(nxt)) begin
                dl = delay_of(nxt);
                m_load = 1;
                m_lval = (1024 - dl) % 1024;
                load_cyc = c + 1;
                ticks_left = (dl == 0) ? 1024 : dl;
            end else begin
                m_load = 0;
            end
            m_state = nxt;
            c++;
            @(negedge clock50);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
